disp_timing_gen: RTL and testbench
==================================

# disp_timing_gen

Display-side consumer of the frame buffer. It generates raster timing (hsync, vsync, data-enable) for a progressive display and issues read enables to the frame buffer's read port in lockstep with the active region. It realigns the returned pixel data so that `pix_out` and `de` leave the block on the same cycle. It sits between the frame buffer read port and the display PHY/encoder, running entirely in the frame buffer's read clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 24: pixel width; must match the frame buffer.
- `H_ACTIVE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: asserted level of hsync/vsync (0 = active-low).
- `RD_LATENCY`, 1: cycles from `fb_rd_en` asserted to valid `fb_rd_data`.

Derived values:
- `H_TOTAL` = sum of the four `H_*` parameters.
- `V_TOTAL` = sum of the four `V_*` parameters.
- `HW` = clog2(`H_TOTAL`); `VW` = clog2(`V_TOTAL`).

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: pixel clock; connects to the frame buffer `rd_clk`.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: run request, level-sensitive.
- `fb_rd_en`, out, 1: frame buffer read enable, active-low (0 = read), matching the frame buffer enable convention.
- `fb_rd_data`, in, `DATA_WIDTH`: frame buffer read data.
- `hsync`, out, 1: horizontal sync, level given by `SYNC_POL`.
- `vsync`, out, 1: vertical sync, level given by `SYNC_POL`.
- `de`, out, 1: data enable, active-high.
- `pix_out`, out, `DATA_WIDTH`: pixel data; all zeros when `de`=0.
- `frame_start`, out, 1: one-cycle pulse coincident with the first `de` of each frame.
- `h_cnt`, out, `HW`: raw horizontal counter (debug).
- `v_cnt`, out, `VW`: raw vertical counter (debug).

## Operation
State machine with two states, IDLE and RUN.

IDLE:
- `h_cnt` and `v_cnt` are held at 0.
- `fb_rd_en`=1 (deasserted).
- Transitions to RUN on the first edge that sees `enable`=1. Counting starts at (0,0) on the following cycle.

RUN:
- `h_cnt` increments every cycle.
- At `H_TOTAL`-1, `h_cnt` wraps to 0 and `v_cnt` increments.
- At `V_TOTAL`-1, `v_cnt` wraps to 0.
- `enable` is sampled only at the last pixel of a frame (`h_cnt`=`H_TOTAL`-1, `v_cnt`=`V_TOTAL`-1). If it is 0, the next state is IDLE. Frames are never truncated by `enable`.

Stage-0 decode from the counters:
- Active when `h_cnt` < `H_ACTIVE` and `v_cnt` < `V_ACTIVE`.
- hsync asserted when `H_ACTIVE`+`H_FP` <= `h_cnt` < `H_ACTIVE`+`H_FP`+`H_SYNC`.
- vsync asserted when `V_ACTIVE`+`V_FP` <= `v_cnt` < `V_ACTIVE`+`V_FP`+`V_SYNC`, for whole lines.

Read request and alignment:
- `fb_rd_en` is driven combinationally as 0 whenever the block is in RUN and stage 0 is active. Exactly `H_ACTIVE`×`V_ACTIVE` read cycles occur per frame, which matches the frame buffer's sequential read address walk.
- Stage-0 active, hsync, vsync and first-pixel flags pass through a delay line of `RD_LATENCY` registers.
- They are then registered once more, together with `fb_rd_data`, onto the outputs.
- `pix_out` is zero-masked when the delayed active flag is 0.

Reset values (all outputs registered except `fb_rd_en`):
- State = IDLE, `h_cnt`=0, `v_cnt`=0.
- `hsync`=`vsync`=~`SYNC_POL`.
- `de`=0, `pix_out`=0, `frame_start`=0, `fb_rd_en`=1.
- Delay line cleared.

## Timing
- Output latency: `de`, `hsync`, `vsync`, `pix_out` and `frame_start` lag their counter position by `RD_LATENCY`+1 cycles. The `h_cnt`/`v_cnt` outputs are not delayed.
- Pixel ordering: the first `de` of a frame carries the data returned for the first `fb_rd_en`. With `RD_LATENCY`=1 and a read issued at cycle t, `pix_out` is valid at t+2.
- Transition into IDLE:
  - `fb_rd_en` rises to 1 immediately, since it is combinational on state.
  - The delay line drains naturally. The last line's blanking outputs finish with their normal values.
  - Thereafter `hsync`/`vsync` sit deasserted and `de`=0.
- Reset mid-frame: on the edge where `reset`=1, all outputs take their reset values and in-flight pipeline entries are discarded. `fb_rd_en`=1 from that cycle onward. There is no partial line or pulse.
- Simultaneous `enable`=0 and reset: reset wins.
- `enable` toggling mid-frame in RUN has no effect.
- Line and frame wrap happen on the same edge: at (`H_TOTAL`-1, `V_TOTAL`-1) both counters return to 0.

## Test plan
Bench parameters for scenarios 1–4: `H_ACTIVE`=4, `H_FP`=1, `H_SYNC`=2, `H_BP`=1, `V_ACTIVE`=3, `V_FP`=1, `V_SYNC`=1, `V_BP`=1 (so `H_TOTAL`=8, `V_TOTAL`=6), `SYNC_POL`=0, `RD_LATENCY`=1. The frame buffer model returns the read count 1, 2, 3, …

1. Reset with `enable`=0 for 10 cycles -> `fb_rd_en`=1, `de`=0, `hsync`=`vsync`=1, `pix_out`=0 throughout.
2. Raise `enable` -> `fb_rd_en`=0 for 4 of every 8 cycles on lines 0–2; `de` lags by 2 cycles; `pix_out` carries 1–12 in order; `frame_start` is high with `pix_out`=1 only.
3. Run 2 frames -> `hsync`=0 for exactly 2 cycles per line, starting 5 cycles after line start (+2 latency); `vsync`=0 for exactly one 8-cycle line at `v_cnt`=4; frame period is 48 cycles.
4. Drop `enable` at `v_cnt`=1 -> the current frame completes (12 reads); IDLE follows at the 48-cycle boundary with no further reads.
5. Assert `reset` at `h_cnt`=2, `v_cnt`=1 -> the next cycle shows all outputs at reset values with no stray `de`. After release with `enable`=1, the first `pix_out` again equals the first read.
6. Bench override `RD_LATENCY`=3 -> `de` and `pix_out` lag `fb_rd_en` by 4 cycles, and `hsync` alignment shifts identically.

Source files
------------

// File: rtl/disp_timing_gen.sv
// disp_timing_gen: raster timing generator; clk/reset/enable in, fb_rd_en/fb_rd_data to frame buffer, hsync/vsync/de/pix_out/frame_start/h_cnt/v_cnt out
module disp_timing_gen #(
    parameter int   DATA_WIDTH = 24,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   RD_LATENCY = 1,
    localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW         = $clog2(H_TOTAL),
    localparam int  VW         = $clog2(V_TOTAL)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  fb_rd_en,
    input  logic [DATA_WIDTH-1:0] fb_rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  frame_start,
    output logic [HW-1:0]         h_cnt,
    output logic [VW-1:0]         v_cnt
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic h_last, last, act0, hs0, vs0, first0, run;
    logic [3:0] dl [RD_LATENCY];
    logic [3:0] d;
    always_comb begin
        h_last = h_cnt == HW'(H_TOTAL - 1);
        last   = h_last && v_cnt == VW'(V_TOTAL - 1);
        act0   = 32'(h_cnt) < H_ACTIVE && 32'(v_cnt) < V_ACTIVE;
        hs0    = 32'(h_cnt) >= H_ACTIVE + H_FP && 32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC;
        vs0    = 32'(v_cnt) >= V_ACTIVE + V_FP && 32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC;
        first0 = h_cnt == '0 && v_cnt == '0;
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;
    always_comb
        state_nxt = state == IDLE ? (enable ? RUN : IDLE) : (last && !enable ? IDLE : RUN);
    always_comb begin
        run      = state == RUN;
        fb_rd_en = !(run && act0);
    end
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + HW'(1);
            if (h_last)
                v_cnt <= v_cnt == VW'(V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
        end
    end
    // stage-0 flags are gated by run so an idle block feeds blanking into the pipe
    always_ff @(posedge clk) begin
        dl[0] <= reset ? 4'b0 : {run && act0, run && hs0, run && vs0, run && first0};
        for (int i = 1; i < RD_LATENCY; i++)
            dl[i] <= reset ? 4'b0 : dl[i-1];
    end
    assign d = dl[RD_LATENCY-1];
    always_ff @(posedge clk) begin
        if (reset) begin
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            pix_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            de          <= d[3];
            hsync       <= d[2] ? SYNC_POL : ~SYNC_POL;
            vsync       <= d[1] ? SYNC_POL : ~SYNC_POL;
            pix_out     <= d[3] ? fb_rd_data : '0;
            frame_start <= d[0];
        end
    end
endmodule

// File: tb/tb_disp_timing_gen.sv
// tb_disp_timing_gen: scoreboard bench for disp_timing_gen at read latency 1 and 3
module tb_disp_timing_gen;
    localparam int DW = 24;
    typedef struct {
        int          due;
        logic [27:0] v;
    } exp_t;
    localparam logic [27:0] IDLE_V = {1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic rd_en_a, rd_en_b, hs_a, hs_b, vs_a, vs_b, de_a, de_b, fs_a, fs_b;
    logic [DW-1:0] data_a = '0, data_b = '0, s1 = '0, s2 = '0, pix_a, pix_b;
    logic [2:0] h_a, h_b, v_a, v_b;
    int cyc = 0, vecs = 0, miss = 0, cnt_a = 0, cnt_b = 0, px = 0, mh = 0, mv = 0;
    logic m_run = 1'b0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;

    disp_timing_gen #(.DATA_WIDTH(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0), .RD_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .fb_rd_en(rd_en_a), .fb_rd_data(data_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .pix_out(pix_a), .frame_start(fs_a),
        .h_cnt(h_a), .v_cnt(v_a));

    disp_timing_gen #(.DATA_WIDTH(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0), .RD_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .fb_rd_en(rd_en_b), .fb_rd_data(data_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .pix_out(pix_b), .frame_start(fs_b),
        .h_cnt(h_b), .v_cnt(v_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // frame buffer models: each returns its running read count
    always @(posedge clk)
        if (!rd_en_a) begin
            cnt_a  <= cnt_a + 1;
            data_a <= DW'(cnt_a + 1);
        end
    always @(posedge clk) begin
        s1     <= rd_en_b ? '0 : DW'(cnt_b + 1);
        s2     <= s1;
        data_b <= s2;
        if (!rd_en_b) cnt_b <= cnt_b + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [27:0] expect_at(input logic r, input int h, input int v, input int p);
        logic a;
        a = h < 4 && v < 3;
        return r ? {a, !(h >= 5 && h < 7), !(v == 4), h == 0 && v == 0, a ? DW'(p) : 24'd0} : IDLE_V;
    endfunction

    task automatic idle_fill(input int from);
        exp_t x;
        x.v = IDLE_V;
        for (int d = from; d <= from + 1; d++) begin x.due = d; qa.push_back(x); end
        for (int d = from; d <= from + 3; d++) begin x.due = d; qb.push_back(x); end
    endtask

    // one cycle: check undelayed signals, queue the delayed expectation, set inputs for the next edge
    task automatic step(input logic rv, input logic ev);
        exp_t x;
        logic act;
        @(posedge clk);
        #1;
        act = m_run && mh < 4 && mv < 3;
        check("rd_en_a", rd_en_a, !act);
        check("rd_en_b", rd_en_b, !act);
        check("cnt_a", {h_a, v_a}, {3'(mh), 3'(mv)});
        check("cnt_b", {h_b, v_b}, {3'(mh), 3'(mv)});
        if (act) px++;
        x.v = expect_at(m_run, mh, mv, px);
        x.due = cyc + 2;
        qa.push_back(x);
        x.due = cyc + 4;
        qb.push_back(x);
        reset = rv;
        enable = ev;
        if (rv) begin
            m_run = 1'b0;
            mh = 0;
            mv = 0;
            qa.delete();
            qb.delete();
            idle_fill(cyc + 1);
        end else if (!m_run) begin
            m_run = ev;
        end else begin
            if (mh == 7 && mv == 5 && !ev) m_run = 1'b0;
            if (mh == 7) begin
                mh = 0;
                mv = mv == 5 ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0 && qa[0].due == cyc) begin
            ea = qa.pop_front();
            check("out_a", {de_a, hs_a, vs_a, fs_a, pix_a}, ea.v);
        end
        if (qb.size() != 0 && qb[0].due == cyc) begin
            eb = qb.pop_front();
            check("out_b", {de_b, hs_b, vs_b, fs_b, pix_b}, eb.v);
        end
    end

    initial begin
        idle_fill(1);
        repeat (10) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (104) step(1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        check("reads_a_3frames", cnt_a, 36);
        check("reads_b_3frames", cnt_b, 36);
        step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (56) step(1'b0, 1'b1);
        check("reads_a_end", cnt_a, 59);
        check("reads_b_end", cnt_b, 59);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
